// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I main control FSM with retire counter and memory-wait watchdog.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap and a sticky illegal output is added.
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             timeout
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [2:0]       f3_q, f3_d;
    logic [6:0]       f7_q, f7_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             retire;
    logic             legal, wd_fire;
    logic             is_r, is_i, is_ld, is_st, is_br;
    logic             unused_fields;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_q, illegal_d;
`endif

    // funct3/funct7 are held for the ALU decoder; this controller only needs the opcode class
    assign unused_fields = ^{f3_q, f7_q};
    assign legal   = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR};
    assign is_r    = op_q == OP_R;
    assign is_i    = op_q == OP_I;
    assign is_ld   = op_q == OP_LD;
    assign is_st   = op_q == OP_ST;
    assign is_br   = op_q == OP_BR;
    assign wd_fire = wait_q == 8'(WAIT_MAX);
    assign cnt_d   = cnt_q + CNT_W'(retire);

    // next-state, watchdog and control outputs; everything stays idle while reset is high
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        f3_d          = f3_q;
        f7_d          = f7_q;
        wait_d        = '0;
        timeout_d     = timeout_q;
        retire        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_src_b     = 1'b0;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`endif
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else if (wd_fire) begin
                        state_d   = TRAP;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                DECODE: begin
                    op_d = opcode;
                    f3_d = funct3;
                    f7_d = funct7;
                    if (legal) begin
                        state_d = EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_d   = TRAP;
                        illegal_d = 1'b1;
`else
                        state_d = FETCH;
                        retire  = 1'b1;
`endif
                    end
                end
                EXEC: begin
                    alu_op        = (is_r || is_i) ? 2'b10 : is_br ? 2'b01 : 2'b00;
                    alu_src_b     = !(is_r || is_br);
                    pc_write_cond = is_br;
                    retire        = is_br;
                    state_d       = is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
                end
                MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = is_ld;
                    mem_write = is_st;
                    if (mem_ready) begin
                        state_d = is_ld ? WB : FETCH;
                        retire  = is_st;
                    end else if (wd_fire) begin
                        state_d   = TRAP;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_ld;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
                TRAP: state_d = TRAP;
                default: state_d = FETCH;
            endcase
        end
    end

    // state, latched fields, counters and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            wait_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
    assign timeout     = timeout_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked against a per-instruction phase model.
module tb_multicycle_ctrl;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

    // control vector bit weights: {mem_read, mem_write, i_or_d, ir_write, pc_write,
    // pc_write_cond, alu_src_b, alu_op[1:0], reg_write, mem_to_reg}
    localparam logic [10:0] MR = 11'h400, MW = 11'h200, IOD = 11'h100, IRW = 11'h080,
                            PCW = 11'h040, PCC = 11'h020, SRCB = 11'h010, AOP10 = 11'h008,
                            AOP01 = 11'h004, RW = 11'h002, M2R = 11'h001;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;
`ifdef ILLEGAL_TRAP_EN
    localparam int NK = 5;
`else
    localparam int NK = 6;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       opcode = '0;
    logic [2:0]       funct3 = '0;
    logic [6:0]       funct7 = '0;
    logic             mem_ready = 1'b0;
    logic             mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic             alu_src_b, reg_write, mem_to_reg, timeout;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic [10:0]      ctrl;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal;
`endif

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             exp_to = 1'b0;
    logic             exp_ill = 1'b0;

    always #5 clk = ~clk;

    assign ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                   alu_src_b, alu_op, reg_write, mem_to_reg};

    multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .state(state), .instr_count(instr_count), .timeout(timeout)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    function automatic logic [6:0] op_of(input int k);
        return k == K_R ? 7'h33 : k == K_I ? 7'h13 : k == K_LD ? 7'h03 :
               k == K_ST ? 7'h23 : k == K_BR ? 7'h63 : 7'h7F;
    endfunction

    function automatic logic [10:0] exec_ctrl(input int k);
        return k == K_R ? AOP10 : k == K_I ? (AOP10 | SRCB) : k == K_BR ? (AOP01 | PCC) : SRCB;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive inputs at the falling edge, then check outputs
    task automatic step(input logic [2:0] es, input logic [10:0] ec, input logic rdy,
                        input logic [6:0] op, input string tag);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = rdy;
        opcode = op;
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        #1;
        check({tag, "_state"}, 32'(state), 32'(es));
        check({tag, "_ctrl"}, 32'(ctrl), 32'(ec));
        check({tag, "_count"}, 32'(instr_count), 32'(exp_cnt));
        check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
`ifdef ILLEGAL_TRAP_EN
        check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
`endif
    endtask

    task automatic reset_seq();
        exp_cnt = '0;
        exp_to = 1'b0;
        exp_ill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1;
            mem_ready = 1'($urandom);
            opcode = 7'($urandom);
            #1;
            check("rst_ctrl", 32'(ctrl), 32'd0);
            if (i > 0) begin
                check("rst_state", 32'(state), 32'(S_FETCH));
                check("rst_count", 32'(instr_count), 32'd0);
                check("rst_timeout", 32'(timeout), 32'd0);
            end
        end
    endtask

    // expected phase sequence of one instruction with wf fetch waits and wm memory waits
    task automatic do_instr(input int k, input int wf, input int wm);
        logic [10:0] mc;
        for (int i = 0; i < wf; i++) step(S_FETCH, MR, 1'b0, 7'($urandom), "fetch_wait");
        step(S_FETCH, MR | IRW | PCW, 1'b1, 7'($urandom), "fetch");
        step(S_DECODE, 11'h0, 1'($urandom), op_of(k), "decode");
        if (k == K_ILL) begin
            exp_cnt++;
            return;
        end
        step(S_EXEC, exec_ctrl(k), 1'($urandom), 7'($urandom), "exec");
        if (k == K_BR) begin
            exp_cnt++;
            return;
        end
        if (k == K_LD || k == K_ST) begin
            mc = IOD | (k == K_LD ? MR : MW);
            for (int i = 0; i < wm; i++) step(S_MEM, mc, 1'b0, 7'($urandom), "mem_wait");
            step(S_MEM, mc, 1'b1, 7'($urandom), "mem");
            if (k == K_ST) begin
                exp_cnt++;
                return;
            end
        end
        step(S_WB, RW | (k == K_LD ? M2R : 11'h0), 1'($urandom), 7'($urandom), "wb");
        exp_cnt++;
    endtask

    initial begin
        reset_seq();
        do_instr(K_R, 0, 0);
        do_instr(K_LD, 0, 2);
        do_instr(K_ST, 0, 0);
        do_instr(K_BR, 0, 0);
        do_instr(K_LD, WAIT_MAX, WAIT_MAX);
`ifndef ILLEGAL_TRAP_EN
        do_instr(K_ILL, 0, 0);
`endif
        for (int n = 0; n < 60; n++) begin
            int k, wf, wm;
            k  = int'($urandom_range(NK - 1));
            wf = ($urandom_range(7) == 0) ? WAIT_MAX : int'($urandom_range(3));
            wm = ($urandom_range(7) == 0) ? WAIT_MAX : int'($urandom_range(3));
            do_instr(k, wf, wm);
        end
        // reset arriving while a load waits in MEM
        step(S_FETCH, MR | IRW | PCW, 1'b1, 7'($urandom), "ld_fetch");
        step(S_DECODE, 11'h0, 1'b0, op_of(K_LD), "ld_decode");
        step(S_EXEC, SRCB, 1'b0, 7'($urandom), "ld_exec");
        step(S_MEM, IOD | MR, 1'b0, 7'($urandom), "ld_mem");
        reset_seq();
        do_instr(K_R, 0, 0);
        // watchdog fires in FETCH
        for (int i = 0; i <= WAIT_MAX; i++) step(S_FETCH, MR, 1'b0, 7'($urandom), "wd_fetch");
        exp_to = 1'b1;
        repeat (4) step(S_TRAP, 11'h0, 1'($urandom), 7'($urandom), "wd_trap");
        reset_seq();
        do_instr(K_BR, 0, 0);
        // watchdog fires in MEM during a store
        step(S_FETCH, MR | IRW | PCW, 1'b1, 7'($urandom), "st_fetch");
        step(S_DECODE, 11'h0, 1'b0, op_of(K_ST), "st_decode");
        step(S_EXEC, SRCB, 1'b0, 7'($urandom), "st_exec");
        for (int i = 0; i <= WAIT_MAX; i++) step(S_MEM, IOD | MW, 1'b0, 7'($urandom), "wd_mem");
        exp_to = 1'b1;
        repeat (3) step(S_TRAP, 11'h0, 1'($urandom), 7'($urandom), "wd_mem_trap");
`ifdef ILLEGAL_TRAP_EN
        reset_seq();
        do_instr(K_R, 0, 0);
        step(S_FETCH, MR | IRW | PCW, 1'b1, 7'($urandom), "ill_fetch");
        step(S_DECODE, 11'h0, 1'b0, op_of(K_ILL), "ill_decode");
        exp_ill = 1'b1;
        repeat (3) step(S_TRAP, 11'h0, 1'($urandom), 7'($urandom), "ill_trap");
`endif
        reset_seq();
        do_instr(K_R, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
